// File: rtl/trans_ctrl.sv
// trans_ctrl: sequencer for the matrix-transpose datapath.
// It collects a size x size matrix row by row on the in_* stream.
// It then emits the transposed matrix, one row per handshake, on the out_* stream.
// Optional build macro TRANS_CTRL_ERR_EN adds the err port. err reports a start
// received while busy, and an illegal size that has been clamped to DIM.
module trans_ctrl #(
  parameter int unsigned DIM = 5,
  parameter int unsigned EW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          size,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIM*EW-1:0]   in_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIM*EW-1:0]   out_row,
  output logic                busy,
  output logic                done
`ifdef TRANS_CTRL_ERR_EN
  ,output logic               err
`endif
);

  localparam int unsigned RW = DIM * EW;
  localparam logic [2:0]  DIM3 = 3'(DIM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] r_q, r_d;
  logic [2:0] k_q, k_d;
  logic [2:0] sz_q, sz_d;
  logic [EW-1:0] buf_q [DIM][DIM];
  logic [EW-1:0] buf_d [DIM][DIM];
  logic [RW-1:0] out_row_d;
  logic          size_bad;
`ifdef TRANS_CTRL_ERR_EN
  logic          err_d;
`endif

  // Size values outside 1..DIM run as a full DIM x DIM operation
  assign size_bad = (size == 3'd0) || (size > DIM3);

  // State, counters and row buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= 3'd0;
      k_q     <= 3'd0;
      sz_q    <= 3'd0;
      for (int unsigned i = 0; i < DIM; i++) begin
        for (int unsigned j = 0; j < DIM; j++) begin
          buf_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      sz_q    <= sz_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state, counter, buffer-write and next-output-row logic
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    k_d       = k_q;
    sz_d      = sz_q;
    buf_d     = buf_q;
    out_row_d = '0;
`ifdef TRANS_CTRL_ERR_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sz_d    = size_bad ? DIM3 : size;
          r_d     = 3'd0;
          state_d = LOAD;
`ifdef TRANS_CTRL_ERR_EN
          err_d   = size_bad;
`endif
        end
      end
      LOAD: begin
`ifdef TRANS_CTRL_ERR_EN
        err_d = start;
`endif
        if (in_valid && in_ready) begin
          // Columns past the active size are zeroed so padding reads as 0
          for (int unsigned c = 0; c < DIM; c++) begin
            buf_d[r_q][c] = (3'(c) < sz_q) ? in_row[RW-1-c*EW -: EW] : '0;
          end
          if (r_q == sz_q - 3'd1) begin
            r_d     = 3'd0;
            k_d     = 3'd0;
            state_d = DRAIN;
          end else begin
            r_d = r_q + 3'd1;
          end
        end
      end
      DRAIN: begin
`ifdef TRANS_CTRL_ERR_EN
        err_d = start;
`endif
        if (out_valid && out_ready) begin
          if (k_q == sz_q - 3'd1) begin
            k_d     = 3'd0;
            state_d = DONE;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      DONE: begin
`ifdef TRANS_CTRL_ERR_EN
        err_d   = start;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The output row comes from the post-edge buffer. The first transposed row
    // is therefore ready in the cycle right after the last input handshake.
    if (state_d == DRAIN) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        if (3'(j) < sz_d) begin
          out_row_d[RW-1-j*EW -: EW] = buf_d[j][k_d];
        end
      end
    end
  end

  // Registered outputs, decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_ready  <= (state_d == LOAD);
      out_valid <= (state_d == DRAIN);
      out_row   <= out_row_d;
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
    end
  end

`ifdef TRANS_CTRL_ERR_EN
  // One-cycle error pulse for an ignored start or a clamped size
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_trans_ctrl.sv
// Testbench for trans_ctrl. Expected transposed rows are computed from the
// driven rows and queued. Each row is popped from the queue at its output handshake.
module tb_trans_ctrl;

  localparam int unsigned DIM = 5;
  localparam int unsigned EW  = 8;
  localparam int unsigned RW  = DIM * EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    size;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_row;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic          busy;
  logic          done;
`ifdef TRANS_CTRL_ERR_EN
  logic          err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] rows [DIM];
  logic [RW-1:0] exp_q [$];

  always #5 clk = ~clk;

  trans_ctrl #(.DIM(DIM), .EW(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .size      (size),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .busy      (busy),
    .done      (done)
`ifdef TRANS_CTRL_ERR_EN
    ,.err      (err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: start, load, drain.
  // bp_at is the handshake index at which out_ready is held low for 3 cycles.
  // rst_after is the handshake count after which reset is asserted.
  // pulse_start sends a stray start during LOAD.
  task automatic run_op(input logic [2:0] sz_in, input int bp_at,
                        input int rst_after, input bit pulse_start);
    int eff;
    int hs;
    int cyc;
    int stall;
    logic [RW-1:0] e;
    logic [RW-1:0] held;
    bit bad;
    bad  = (sz_in == 3'd0) || (sz_in > 3'(DIM));
    eff  = bad ? int'(DIM) : int'(sz_in);
    held = '0;
    start = 1'b1;
    size  = sz_in;
    tick();
    start = 1'b0;
    size  = 3'($urandom_range(0, 7));
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_accept: busy=%b in_ready=%b, required 1/1", busy, in_ready);
    end
`ifdef TRANS_CTRL_ERR_EN
    n_checks++;
    if (err !== bad) begin
      n_fail++;
      $display("FAIL err_size: err=%b, required %b", err, bad);
    end
`endif
    for (int i = 0; i < eff; i++) begin
      in_valid = 1'b1;
      in_row   = rows[i];
      start    = pulse_start && (i == 1);
      tick();
      start    = 1'b0;
`ifdef TRANS_CTRL_ERR_EN
      if (pulse_start && (i == 1)) begin
        n_checks++;
        if (err !== 1'b1) begin
          n_fail++;
          $display("FAIL err_busy: err=%b, required 1", err);
        end
      end
`endif
    end
    in_valid = 1'b0;
    in_row   = {$urandom, 8'($urandom)};
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL load_to_drain: in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
    end
    // Model: output row k, slot j = element k of input row j; slots past size are 0
    for (int k = 0; k < eff; k++) begin
      e = '0;
      for (int j = 0; j < eff; j++) begin
        e[RW-1-j*EW -: EW] = rows[j][RW-1-k*EW -: EW];
      end
      exp_q.push_back(e);
    end
    hs = 0; cyc = 0; stall = 0;
    while (hs < eff && cyc < 200) begin
      cyc++;
      out_ready = !((hs == bp_at) && (stall < 3));
      if (out_valid !== 1'b1) begin
        n_checks++; n_fail++;
        $display("FAIL drain_valid: out_valid=%b at handshake %0d, required 1", out_valid, hs);
      end else if (!out_ready) begin
        if (stall > 0) begin
          n_checks++;
          if (out_row !== held) begin
            n_fail++;
            $display("FAIL hold_row: out_row=%h, required %h", out_row, held);
          end
        end
        held = out_row;
        stall++;
      end else begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (out_row !== e) begin
          n_fail++;
          $display("FAIL out_row[%0d]: got %h, required %h", hs, out_row, e);
        end
        hs++;
      end
      tick();
      if (hs == rst_after) begin
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, done} !== 4'b0 || out_row !== '0) begin
          n_fail++;
          $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b done=%b out_row=%h, required all 0",
                   in_ready, out_valid, busy, done, out_row);
        end
        for (int i = 0; i < 3; i++) begin
          tick();
          n_checks++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: done=%b busy=%b, required 0/0", done, busy);
          end
        end
        rst = 1'b0;
        exp_q.delete();
        tick();
        return;
      end
    end
    n_checks++;
    if (hs != eff) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d handshakes, required %0d", hs, eff);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b out_valid=%b, required 1/1/0", done, busy, out_valid);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_end: done=%b busy=%b, required 0/0", done, busy);
    end
    out_ready = 1'b1;
  endtask

  task automatic load_full5();
    rows[0] = 40'h0102030405; rows[1] = 40'h060708090A; rows[2] = 40'h0B0C0D0E0F;
    rows[3] = 40'h1011121314; rows[4] = 40'h1516171819;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0 || out_row !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b done=%b out_row=%h, required all 0",
               in_ready, out_valid, busy, done, out_row);
    end
`ifdef TRANS_CTRL_ERR_EN
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: err=%b, required 0", err);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_accept: in_ready=%b busy=%b, required 0/0", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full5();
    load_full5();
    run_op(3'd5, -1, -1, 1'b0);
  endtask

  task automatic test_reduced3();
    rows[0] = 40'h010203FFFF; rows[1] = 40'h040506FFFF; rows[2] = 40'h070809FFFF;
    run_op(3'd3, -1, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    load_full5();
    run_op(3'd5, 2, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    load_full5();
    run_op(3'd5, -1, 2, 1'b0);
    for (int i = 0; i < DIM; i++) rows[i] = {$urandom, 8'($urandom)};
    run_op(3'd5, -1, -1, 1'b0);
  endtask

  task automatic test_start_busy();
    load_full5();
    run_op(3'd5, -1, -1, 1'b1);
  endtask

  task automatic test_illegal_size();
    for (int i = 0; i < DIM; i++) rows[i] = {$urandom, 8'($urandom)};
    run_op(3'd0, -1, -1, 1'b0);
    for (int i = 0; i < DIM; i++) rows[i] = {$urandom, 8'($urandom)};
    run_op(3'd7, 1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 1; n <= 4; n++) begin
      for (int i = 0; i < DIM; i++) rows[i] = {$urandom, 8'($urandom)};
      run_op(3'(n), n - 1, -1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; size = 3'd0; in_valid = 1'b0;
    in_row = '0; out_ready = 1'b1;
    test_reset();
    test_full5();
    test_reduced3();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_illegal_size();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
